// File: rtl/fft_twiddle_mult.sv
// Radix-2^2 twiddle multiplier: indexes a twiddle ROM by local sample position and
// forms the complex product over a 3-stage pipeline. Define FFT_TW_ROUND_EN for round-half-up.
module fft_twiddle_mult #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int N_POINTS   = 16,
    parameter int STAGE      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync,
    input  logic signed [DATA_WIDTH-1:0]  a_re,
    input  logic signed [DATA_WIDTH-1:0]  a_im,
    output logic signed [DATA_WIDTH-1:0]  b_re,
    output logic signed [DATA_WIDTH-1:0]  b_im,
    output logic                          out_valid,
    output logic                          out_sync
);

    localparam int  L      = N_POINTS >> (2 * STAGE);
    localparam int  LW     = $clog2(L);
    localparam int  QW     = L / 4;
    localparam int  PW     = DATA_WIDTH + TW_WIDTH;
    localparam int  SW     = PW + 1;
    localparam int  TW_MAX = (1 << (TW_WIDTH - 1)) - 1;
    localparam int  TW_MIN = -(1 << (TW_WIDTH - 1));
    localparam real PI     = 3.14159265358979323846;

    function automatic int tw_exp(input int n);
        int q;
        int r;
        int m;
        q = n / QW;
        r = n % QW;
        case (q)
            0:       m = 0;
            1:       m = 2;
            2:       m = 1;
            default: m = 3;
        endcase
        return r * m;
    endfunction

    // Round half away from zero, then clamp (+1.0 is not representable)
    function automatic logic signed [TW_WIDTH-1:0] tw_quant(input real v);
        real s;
        int  k;
        s = v * (2.0 ** (TW_WIDTH - 1));
        k = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        if (k > TW_MAX)
            k = TW_MAX;
        else if (k < TW_MIN)
            k = TW_MIN;
        return k[TW_WIDTH-1:0];
    endfunction

    function automatic logic signed [TW_WIDTH-1:0] tw_re(input int n);
        return tw_quant($cos(2.0 * PI * real'(tw_exp(n)) / real'(L)));
    endfunction

    function automatic logic signed [TW_WIDTH-1:0] tw_im(input int n);
        return tw_quant(-$sin(2.0 * PI * real'(tw_exp(n)) / real'(L)));
    endfunction

    function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
`ifdef FFT_TW_ROUND_EN
        logic signed [SW-1:0] t;
        t = s + {{(SW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
        return t >>> (TW_WIDTH - 1);
`else
        return s >>> (TW_WIDTH - 1);
`endif
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
        if (v[SW-1:DATA_WIDTH-1] == {(SW-DATA_WIDTH+1){v[SW-1]}})
            return v[DATA_WIDTH-1:0];
        else if (v[SW-1])
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    // ROM indexed directly by local position n; entry holds W^(r*m)
    logic signed [TW_WIDTH-1:0] rom_re [L];
    logic signed [TW_WIDTH-1:0] rom_im [L];

    for (genvar i = 0; i < L; i++) begin : g_rom
        assign rom_re[i] = tw_re(i);
        assign rom_im[i] = tw_im(i);
    end

    logic [LW-1:0] cnt;
    logic [LW-1:0] idx;
    logic          bypass;

    assign idx    = sync ? '0 : cnt;
    assign bypass = (idx[LW-1:LW-2] == 2'b00) || (idx[LW-3:0] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (en)
            cnt <= idx + 1'b1;
    end

    // Stage 1: input register and ROM read
    logic signed [DATA_WIDTH-1:0] a_re_p0, a_im_p0;
    logic signed [TW_WIDTH-1:0]   w_re_p0, w_im_p0;
    logic                         byp_p0, vld_p0, sync_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_re_p0 <= '0;
            a_im_p0 <= '0;
            w_re_p0 <= '0;
            w_im_p0 <= '0;
            byp_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            sync_p0 <= 1'b0;
        end else begin
            a_re_p0 <= a_re;
            a_im_p0 <= a_im;
            w_re_p0 <= rom_re[idx];
            w_im_p0 <= rom_im[idx];
            byp_p0  <= bypass;
            vld_p0  <= en;
            sync_p0 <= en & sync;
        end
    end

    // Stage 2: full-precision partial products
    logic signed [PW-1:0]         p_rr_p1, p_ii_p1, p_ri_p1, p_ir_p1;
    logic signed [DATA_WIDTH-1:0] a_re_p1, a_im_p1;
    logic                         byp_p1, vld_p1, sync_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rr_p1 <= '0;
            p_ii_p1 <= '0;
            p_ri_p1 <= '0;
            p_ir_p1 <= '0;
            a_re_p1 <= '0;
            a_im_p1 <= '0;
            byp_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            p_rr_p1 <= PW'(a_re_p0) * PW'(w_re_p0);
            p_ii_p1 <= PW'(a_im_p0) * PW'(w_im_p0);
            p_ri_p1 <= PW'(a_re_p0) * PW'(w_im_p0);
            p_ir_p1 <= PW'(a_im_p0) * PW'(w_re_p0);
            a_re_p1 <= a_re_p0;
            a_im_p1 <= a_im_p0;
            byp_p1  <= byp_p0;
            vld_p1  <= vld_p0;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 3: sum, round, saturate; e=0 bypasses the arithmetic for an exact copy
    logic signed [SW-1:0]         sum_re, sum_im;
    logic signed [DATA_WIDTH-1:0] res_re, res_im;

    assign sum_re = SW'(p_rr_p1) - SW'(p_ii_p1);
    assign sum_im = SW'(p_ri_p1) + SW'(p_ir_p1);
    assign res_re = saturate(round_shift(sum_re));
    assign res_im = saturate(round_shift(sum_im));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_re      <= '0;
            b_im      <= '0;
            out_valid <= 1'b0;
            out_sync  <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            out_sync  <= vld_p1 & sync_p1;
            if (vld_p1) begin
                b_re <= byp_p1 ? a_re_p1 : res_re;
                b_im <= byp_p1 ? a_im_p1 : res_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Directed bench for fft_twiddle_mult (N=16, STAGE=0, 16-bit); expectations follow FFT_TW_ROUND_EN.
module tb_fft_twiddle_mult;

    localparam int MAXS = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic sync = 1'b0;
    logic signed [15:0] a_re = '0;
    logic signed [15:0] a_im = '0;
    logic signed [15:0] b_re, b_im;
    logic out_valid, out_sync;

    int checks = 0;
    int errors = 0;

    logic st_en   [MAXS];
    logic st_sync [MAXS];
    int   st_re   [MAXS];
    int   st_im   [MAXS];
    int   nslots;

    logic ob_v  [MAXS+4];
    logic ob_s  [MAXS+4];
    int   ob_re [MAXS+4];
    int   ob_im [MAXS+4];

    always #5 clk = ~clk;

    fft_twiddle_mult #(
        .DATA_WIDTH(16),
        .TW_WIDTH(16),
        .N_POINTS(16),
        .STAGE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync(sync),
        .a_re(a_re),
        .a_im(a_im),
        .b_re(b_re),
        .b_im(b_im),
        .out_valid(out_valid),
        .out_sync(out_sync)
    );

    // Hand-computed responses to input (1000,0) at each local index n
    function automatic int exp_re(input int n);
`ifdef FFT_TW_ROUND_EN
        case (n)
            5, 10:  return 707;
            6:      return 0;
            7, 14:  return -707;
            9:      return 924;
            11, 13: return 383;
            15:     return -924;
            default: return 1000;
        endcase
`else
        case (n)
            5, 10:  return 707;
            6:      return 0;
            7, 14:  return -708;
            9:      return 923;
            11, 13: return 382;
            15:     return -924;
            default: return 1000;
        endcase
`endif
    endfunction

    function automatic int exp_im(input int n);
`ifdef FFT_TW_ROUND_EN
        case (n)
            5, 10:  return -707;
            6:      return -1000;
            7, 14:  return -707;
            9:      return -383;
            11, 13: return -924;
            15:     return 383;
            default: return 0;
        endcase
`else
        case (n)
            5, 10:  return -708;
            6:      return -1000;
            7, 14:  return -708;
            9:      return -383;
            11, 13: return -924;
            15:     return 382;
            default: return 0;
        endcase
`endif
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXS; i++) begin
            st_en[i]   = 1'b0;
            st_sync[i] = 1'b0;
            st_re[i]   = 1000;
            st_im[i]   = 0;
        end
    endtask

    // Output for slot j is captured at record j+3
    task automatic run_stream();
        for (int i = 0; i < nslots + 4; i++) begin
            @(negedge clk);
            ob_v[i]  = out_valid;
            ob_s[i]  = out_sync;
            ob_re[i] = int'(b_re);
            ob_im[i] = int'(b_im);
            if (i < nslots) begin
                en   = st_en[i];
                sync = st_sync[i];
                a_re = st_re[i][15:0];
                a_im = st_im[i][15:0];
            end else begin
                en   = 1'b0;
                sync = 1'b0;
                a_re = '0;
                a_im = '0;
            end
        end
    endtask

    task automatic test_reset();
        en = 1'b1;
        sync = 1'b1;
        a_re = 16'sd500;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", out_valid); end
        checks++; if (out_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %0d want 0", out_sync); end
        checks++; if (b_re !== 16'sd0) begin errors++; $display("FAIL reset_b_re got %0d want 0", b_re); end
        checks++; if (b_im !== 16'sd0) begin errors++; $display("FAIL reset_b_im got %0d want 0", b_im); end
        en = 1'b0;
        sync = 1'b0;
        a_re = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_twiddles();
        clear_stim();
        nslots = 16;
        for (int i = 0; i < 16; i++) st_en[i] = 1'b1;
        st_sync[0] = 1'b1;
        run_stream();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ob_v[i] !== 1'b0) begin errors++; $display("FAIL latency_early_valid rec %0d got %0d want 0", i, ob_v[i]); end
        end
        for (int j = 0; j < 16; j++) begin
            checks++; if (ob_v[j+3] !== 1'b1) begin errors++; $display("FAIL tw_valid n=%0d got %0d want 1", j, ob_v[j+3]); end
            checks++; if (ob_s[j+3] !== (j == 0)) begin errors++; $display("FAIL tw_sync n=%0d got %0d want %0d", j, ob_s[j+3], j == 0); end
            checks++; if (ob_re[j+3] !== exp_re(j)) begin errors++; $display("FAIL tw_re n=%0d got %0d want %0d", j, ob_re[j+3], exp_re(j)); end
            checks++; if (ob_im[j+3] !== exp_im(j)) begin errors++; $display("FAIL tw_im n=%0d got %0d want %0d", j, ob_im[j+3], exp_im(j)); end
        end
        checks++; if (ob_v[19] !== 1'b0) begin errors++; $display("FAIL tw_tail_valid got %0d want 0", ob_v[19]); end
        checks++; if (ob_re[19] !== exp_re(15)) begin errors++; $display("FAIL tw_hold_re got %0d want %0d", ob_re[19], exp_re(15)); end
    endtask

    task automatic test_saturation();
        clear_stim();
        nslots = 7;
        for (int i = 0; i < 7; i++) st_en[i] = 1'b1;
        st_sync[0] = 1'b1;
        st_re[6] = -32768;
        st_im[6] = -32768;
        run_stream();
        checks++; if (ob_v[9] !== 1'b1) begin errors++; $display("FAIL sat_valid got %0d want 1", ob_v[9]); end
        checks++; if (ob_re[9] !== -32768) begin errors++; $display("FAIL sat_re got %0d want -32768", ob_re[9]); end
        checks++; if (ob_im[9] !== 32767) begin errors++; $display("FAIL sat_im got %0d want 32767", ob_im[9]); end
    endtask

    task automatic test_gaps_wrap();
        int n;
        int last_n;
        clear_stim();
        nslots = 48;
        for (int i = 0; i < 48; i++) st_en[i] = (i % 2 == 0);
        st_sync[0] = 1'b1;
        run_stream();
        last_n = 0;
        for (int i = 0; i < 48; i++) begin
            if (st_en[i]) begin
                n = (i / 2) % 16;
                last_n = n;
                checks++; if (ob_v[i+3] !== 1'b1) begin errors++; $display("FAIL gap_valid slot %0d got %0d want 1", i, ob_v[i+3]); end
                checks++; if (ob_s[i+3] !== (i == 0)) begin errors++; $display("FAIL gap_sync slot %0d got %0d want %0d", i, ob_s[i+3], i == 0); end
                checks++; if (ob_re[i+3] !== exp_re(n)) begin errors++; $display("FAIL gap_re slot %0d n=%0d got %0d want %0d", i, n, ob_re[i+3], exp_re(n)); end
                checks++; if (ob_im[i+3] !== exp_im(n)) begin errors++; $display("FAIL gap_im slot %0d n=%0d got %0d want %0d", i, n, ob_im[i+3], exp_im(n)); end
            end else begin
                checks++; if (ob_v[i+3] !== 1'b0) begin errors++; $display("FAIL gap_idle_valid slot %0d got %0d want 0", i, ob_v[i+3]); end
                checks++; if (ob_im[i+3] !== exp_im(last_n)) begin errors++; $display("FAIL gap_hold_im slot %0d got %0d want %0d", i, ob_im[i+3], exp_im(last_n)); end
            end
        end
    endtask

    task automatic test_sync_mid();
        int n;
        clear_stim();
        nslots = 13;
        for (int i = 0; i < 13; i++) st_en[i] = 1'b1;
        st_sync[0] = 1'b1;
        st_sync[7] = 1'b1;
        run_stream();
        for (int j = 0; j < 13; j++) begin
            n = (j < 7) ? j : j - 7;
            checks++; if (ob_s[j+3] !== (j == 0 || j == 7)) begin errors++; $display("FAIL resync_sync slot %0d got %0d want %0d", j, ob_s[j+3], j == 0 || j == 7); end
            checks++; if (ob_re[j+3] !== exp_re(n)) begin errors++; $display("FAIL resync_re slot %0d n=%0d got %0d want %0d", j, n, ob_re[j+3], exp_re(n)); end
            checks++; if (ob_im[j+3] !== exp_im(n)) begin errors++; $display("FAIL resync_im slot %0d n=%0d got %0d want %0d", j, n, ob_im[j+3], exp_im(n)); end
        end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        en = 1'b1; sync = 1'b1; a_re = 16'sd1234; a_im = 16'sd55;
        @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        en = 1'b0;
        a_re = '0;
        a_im = '0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid cyc %0d got %0d want 0", i, out_valid); end
            checks++; if (b_re !== 16'sd0 || b_im !== 16'sd0) begin errors++; $display("FAIL midrst_data cyc %0d got (%0d,%0d) want (0,0)", i, b_re, b_im); end
        end
        rst = 1'b1;
        @(negedge clk);
        clear_stim();
        nslots = 6;
        for (int i = 0; i < 6; i++) st_en[i] = 1'b1;
        run_stream();
        for (int j = 0; j < 6; j++) begin
            checks++; if (ob_v[j+3] !== 1'b1) begin errors++; $display("FAIL postrst_valid n=%0d got %0d want 1", j, ob_v[j+3]); end
            checks++; if (ob_re[j+3] !== exp_re(j)) begin errors++; $display("FAIL postrst_re n=%0d got %0d want %0d", j, ob_re[j+3], exp_re(j)); end
            checks++; if (ob_im[j+3] !== exp_im(j)) begin errors++; $display("FAIL postrst_im n=%0d got %0d want %0d", j, ob_im[j+3], exp_im(j)); end
        end
    endtask

    initial begin
        test_reset();
        test_twiddles();
        test_saturation();
        test_gaps_wrap();
        test_sync_mid();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_twiddle_mult.md
FFT_TWIDDLE_MULT -- requirements
Module: fft_twiddle_mult

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed width of each data component, in and out.
REQ-002 Parameter TW_WIDTH, default 16: signed twiddle component width, Q1.(TW_WIDTH-1).
REQ-003 Parameter N_POINTS, default 16: FFT length; power of 4, at least 16.
REQ-004 Parameter STAGE, default 0: R2^2 stage index; local length L = N_POINTS/4^STAGE; L SHALL be at least 16.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 en  input  1  input sample valid; one sample accepted per cycle with en=1.
REQ-008 sync  input  1  frame start; qualified by en; marks local index 0.
REQ-009 a_re, a_im  input  DATA_WIDTH each  signed sample from the upstream BF-II butterfly.
REQ-010 b_re, b_im  output  DATA_WIDTH each  signed twiddled sample.
REQ-011 out_valid  output  1  b_re/b_im valid this cycle.
REQ-012 out_sync  output  1  sync delayed in step with out_valid.

Function
REQ-013 Local index counter n (log2(L) bits) SHALL increment on each en=1 cycle and wrap from L-1 to 0.
REQ-014 en=1 with sync=1 SHALL process that sample as n=0; the counter SHALL then hold 1, whatever its previous value.
REQ-015 en=0 SHALL leave the counter unchanged.
REQ-016 Quadrant and offset: q = n / (L/4), r = n mod (L/4).
REQ-017 Exponent e = r*m, where m is 0, 2, 1, 3 for q = 0, 1, 2, 3.
REQ-018 Twiddle W = exp(-j*2*pi*e/L).
- Taken from a ROM of L entries, filled at elaboration.
- Each component = round(value * 2^(TW_WIDTH-1)), clamped to [-2^(TW_WIDTH-1), 2^(TW_WIDTH-1)-1].
REQ-019 Output SHALL be the complex product:
- b_re = a_re*w_re - a_im*w_im
- b_im = a_re*w_im + a_im*w_re
REQ-020 Arithmetic width rules:
- Products use full DATA_WIDTH+TW_WIDTH signed precision.
- Sums use one extra bit.
- Result is shifted right by TW_WIDTH-1.
REQ-021 The shifted result SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 When e=0, the output SHALL equal the input exactly (bypass, no rounding error).
REQ-023 Pipeline SHALL be three register stages, with latency exactly 3 cycles from en to out_valid:
- Stage 1: input register and ROM read.
- Stage 2: product register.
- Stage 3: sum, round, saturate, output register.
REQ-024 Pipeline SHALL advance every cycle; valid/sync bits travel alongside data; no backpressure.
REQ-025 When out_valid=0, b_re/b_im SHALL hold their last valid value.
REQ-026 Back-to-back en=1 SHALL sustain one output per cycle with no bubbles.

Reset
REQ-027 rst=0 SHALL asynchronously clear:
- counter n;
- all pipeline data and valid registers;
- b_re, b_im, out_valid, out_sync, all to 0.
REQ-028 Reset mid-frame SHALL discard in-flight samples; the first en after release is n=0.

Configuration
REQ-029 Macro FFT_TW_ROUND_EN defined:
- Adds 2^(TW_WIDTH-2) before the shift (round half up).
- Rounding is applied before saturation.
REQ-030 Macro FFT_TW_ROUND_EN undefined: the shift SHALL truncate toward minus infinity; no adder is present.

Verification (N_POINTS=16, STAGE=0, widths 16, FFT_TW_ROUND_EN defined)
REQ-031 Reset, then n=0..4:
- Stimulus: sync at n=0, 16 samples of (1000,0).
- Response: outputs for n=0..4 exactly (1000,0); first out_valid 3 cycles after first en; out_sync with first output.
REQ-032 Twiddle values, same stream:
- n=5 (e=2) -> (707,-707).
- n=15 (e=9) -> (-924,383).
- Without the macro: n=5 -> (707,-708), n=15 -> (-924,382).
REQ-033 Saturation: input (-32768,-32768) at n=6 (e=4, W=-j) -> (-32768, 32767).
REQ-034 en gaps and wrap:
- en toggled 1,0,1,0 over 20 samples -> twiddle index continues across gaps and wraps 15->0.
- sync asserted at n=7 -> that sample uses e=0 and passes unchanged.
REQ-035 Reset mid-operation:
- Stimulus: assert rst with 2 samples in flight.
- Response: out_valid stays 0 and outputs are 0; the next frame starts at n=0.
